shift_reg_univ: RTL and testbench

- Parametrised universal shift register; successor to the fixed serial-in 16-bit shift register.
- Adds:
  - parallel load
  - rotate mode
  - serial-out bit
  - counted burst-shift engine with a start/busy/done handshake
- Sits between serial front-ends and word-wide datapaths; used for serialisers, deserialisers and barrel-style multi-cycle shifts.

---
 rtl/shift_reg_pkg.sv | 26 ++
 rtl/sr_burst_ctl.sv | 101 ++++++++++
 rtl/shift_reg_univ.sv | 93 +++++++++
 tb/tb_shift_reg_univ.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register.
//   - mode encodings driven on shift_reg_univ.mode
//   - shift direction encodings driven on shift_reg_univ.dir
//   - burst controller state encoding
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_LOAD   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;  // toward MSB
  localparam logic DIR_RIGHT = 1'b1;  // toward LSB

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only SHIFT and ROTATE can run as multi-cycle bursts.
  function automatic logic is_burst_op(input logic [1:0] m);
    return (m == MODE_SHIFT) || (m == MODE_ROTATE);
  endfunction

endpackage

// File: rtl/sr_burst_ctl.sv
// Burst-shift controller: FSM, down-counter and latched mode/dir.
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   en                clock enable (freezes FSM and counter when low)
//   start, count      burst request and length
//   mode, dir         live operation select
//   op_en             apply op_mode/op_dir to the register this edge
//   op_mode, op_dir   operation the datapath should perform
//   busy, done        burst in progress / one-cycle completion pulse
module sr_burst_ctl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic             op_en,
  output logic [1:0]       op_mode,
  output logic             op_dir,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  // Next state, counter and latched op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && start) begin
          mode_d = mode;
          dir_d  = dir;
          if (count == '0) begin
            state_d = ST_DONE;
          end else if (is_burst_op(mode) && count != CNT_W'(1)) begin
            // First shift happens on the start edge, so count-1 remain.
            cnt_d   = count - CNT_W'(1);
            state_d = ST_BUSY;
          end else begin
            // Single-op burst or HOLD/LOAD start: one op, then done.
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (en) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;  // leaves regardless of en
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath control. DONE performs no op and ignores start.
  always_comb begin
    op_en   = 1'b0;
    op_mode = mode;
    op_dir  = dir;
    unique case (state_q)
      ST_IDLE: op_en = en && !(start && count == '0);
      ST_BUSY: begin
        op_en   = en;
        op_mode = mode_q;
        op_dir  = dir_q;
      end
      default: op_en = 1'b0;
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with HOLD/SHIFT/ROTATE/LOAD and a
// counted burst-shift engine (start/busy/done).
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   en               clock enable for register and burst engine
//   mode, dir        operation (HOLD/SHIFT/ROTATE/LOAD), direction (0=left)
//   d                serial input
//   load_val         parallel load value
//   start, count     burst request and length
//   out              register contents
//   so               serial out (out[MSB-1] for left, out[0] for right)
//   busy, done       burst status
//   parity           XOR of out, registered (only with SHIFT_REG_UNIV_PARITY_EN)
// Optional feature macro: SHIFT_REG_UNIV_PARITY_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int MSB   = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             d,
  input  logic [MSB-1:0]   load_val,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [MSB-1:0]   out,
  output logic             so,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_UNIV_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic           op_en;
  logic [1:0]     op_mode;
  logic           op_dir;
  logic [MSB-1:0] out_q, out_d;

  sr_burst_ctl #(.CNT_W(CNT_W)) u_ctl (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .start   (start),
    .count   (count),
    .mode    (mode),
    .dir     (dir),
    .op_en   (op_en),
    .op_mode (op_mode),
    .op_dir  (op_dir),
    .busy    (busy),
    .done    (done)
  );

  always_comb begin
    out_d = out_q;
    if (op_en) begin
      unique case (op_mode)
        MODE_SHIFT:  out_d = (op_dir == DIR_LEFT) ? {out_q[MSB-2:0], d}
                                                  : {d, out_q[MSB-1:1]};
        MODE_ROTATE: out_d = (op_dir == DIR_LEFT) ? {out_q[MSB-2:0], out_q[MSB-1]}
                                                  : {out_q[0], out_q[MSB-1:1]};
        MODE_LOAD:   out_d = load_val;
        default:     out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out = out_q;
  assign so  = (dir == DIR_RIGHT) ? out_q[0] : out_q[MSB-1];

`ifdef SHIFT_REG_UNIV_PARITY_EN
  // Tracks out_d every edge, so it always matches the registered out.
  logic parity_q, parity_d;
  assign parity_d = ^out_d;
  always_ff @(posedge clk) begin
    if (!rstn) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ (MSB=16, CNT_W=5): directed steps followed by
// randomized cycles, all checked against a behavioural reference model.
module tb_shift_reg_univ;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0, en = 1'b0, dir = 1'b0, d = 1'b0, start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  load_val = '0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  out;
  logic          so, busy, done;
`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic          parity;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m = '0;
  int          rem = 0;
  bit          mb = 1'b0, md = 1'b0;
  logic [1:0]  lm = 2'd0;
  logic        ld = 1'b0;

  always #5 clk = ~clk;

  shift_reg_univ #(.MSB(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .d        (d),
    .load_val (load_val),
    .start    (start),
    .count    (count),
    .out      (out),
    .so       (so),
    .busy     (busy),
    .done     (done)
`ifdef SHIFT_REG_UNIV_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  function automatic logic [15:0] apply(input logic [1:0] op, input logic r,
                                        input logic din, input logic [15:0] v,
                                        input logic [15:0] lv);
    int x;
    x = int'(v);
    case (op)
      2'd1: x = r ? ((x >> 1) | (int'(din) << 15)) : ((x << 1) | int'(din));
      2'd2: x = r ? ((x >> 1) | ((x & 1) << 15)) : ((x << 1) | (x >> 15));
      2'd3: x = int'(lv);
      default: ;
    endcase
    return x[15:0];
  endfunction

  // One clock edge of the specified behaviour, using the inputs as sampled.
  task automatic model_step();
    if (!rstn) begin
      m = '0; mb = 1'b0; md = 1'b0; rem = 0;
    end else if (md) begin
      md = 1'b0;
    end else if (mb) begin
      if (en) begin
        m = apply(lm, ld, d, m, load_val);
        rem--;
        if (rem == 0) begin mb = 1'b0; md = 1'b1; end
      end
    end else if (en) begin
      if (start) begin
        if (count == 0) md = 1'b1;
        else begin
          m = apply(mode, dir, d, m, load_val);
          rem = int'(count) - 1;
          if ((mode == 2'd1 || mode == 2'd2) && rem > 0) begin
            mb = 1'b1; lm = mode; ld = dir;
          end else md = 1'b1;
        end
      end else begin
        m = apply(mode, dir, d, m, load_val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out",  32'(out),  32'(m));
    chk("busy", 32'(busy), 32'(mb));
    chk("done", 32'(done), 32'(md));
    chk("so",   32'(so),   32'(dir ? m[0] : m[15]));
`ifdef SHIFT_REG_UNIV_PARITY_EN
    chk("parity", 32'(parity), 32'(^m));
`endif
  endtask

  initial begin
    @(negedge clk);
    // Reset overrides a pending LOAD
    rstn = 1'b0; en = 1'b1; mode = 2'd3; load_val = 16'hFFFF;
    tick(); tick();
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rstn = 1'b1;
    tick();
    chk("load_ffff", 32'(out), 32'hFFFF);

    // Free-running shifts
    load_val = 16'h0001; tick();
    mode = 2'd1; dir = 1'b0; d = 1'b0;
    repeat (3) tick();
    chk("shl3", 32'(out), 32'h0008);
    dir = 1'b1; d = 1'b1; tick();
    chk("shr_d1", 32'(out), 32'h8004);
    mode = 2'd0; dir = 1'b0; #1;
    chk("so_left", 32'(so), 32'h1);
    dir = 1'b1; #1;
    chk("so_right", 32'(so), 32'h0);

    // Rotate burst of 4 with a start attempt while busy
    mode = 2'd3; load_val = 16'h8001; tick();
    mode = 2'd2; dir = 1'b0; start = 1'b1; count = 5'd4; tick();
    chk("rb_busy1", 32'(busy), 32'h1);
    start = 1'b0; tick();
    start = 1'b1; count = 5'd7; mode = 2'd1; tick();
    chk("rb_busy3", 32'(busy), 32'h1);
    start = 1'b0; mode = 2'd0; tick();
    chk("rb_done", 32'(done), 32'h1);
    chk("rb_out", 32'(out), 32'h0018);
    tick();
    chk("rb_done_clr", 32'(done), 32'h0);

    // Same burst stalled for two cycles
    mode = 2'd3; load_val = 16'h8001; tick();
    mode = 2'd2; dir = 1'b0; start = 1'b1; count = 5'd4; tick();
    start = 1'b0; mode = 2'd0; tick();
    en = 1'b0; tick(); tick();
    chk("stall_out", 32'(out), 32'h0006);
    chk("stall_busy", 32'(busy), 32'h1);
    en = 1'b1; tick(); tick();
    chk("stall_done", 32'(done), 32'h1);
    chk("stall_out_fin", 32'(out), 32'h0018);
    tick();

    // count=0: done next cycle, no shift
    mode = 2'd1; dir = 1'b0; d = 1'b1; start = 1'b1; count = 5'd0; tick();
    chk("c0_done", 32'(done), 32'h1);
    chk("c0_out", 32'(out), 32'h0018);
    start = 1'b0; mode = 2'd0; tick();

    // count > width flushes with d
    mode = 2'd3; load_val = 16'h0000; tick();
    mode = 2'd1; dir = 1'b1; d = 1'b1; start = 1'b1; count = 5'd20; tick();
    start = 1'b0;
    repeat (19) tick();
    chk("c20_done", 32'(done), 32'h1);
    chk("c20_out", 32'(out), 32'hFFFF);
    mode = 2'd0; tick();

    // Reset mid-burst aborts with no done
    mode = 2'd2; dir = 1'b0; start = 1'b1; count = 5'd10; tick();
    start = 1'b0; tick();
    rstn = 1'b0; tick();
    chk("mrst_out", 32'(out), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    rstn = 1'b1; mode = 2'd0; tick();
    chk("mrst_nodone", 32'(done), 32'h0);

`ifdef SHIFT_REG_UNIV_PARITY_EN
    mode = 2'd3; load_val = 16'h0007; tick();
    chk("par7", 32'(parity), 32'h1);
    load_val = 16'h0003; tick();
    chk("par3", 32'(parity), 32'h0);
`endif

    // Randomized cycles
    repeat (600) begin
      rstn     = ($urandom_range(0, 79) != 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      dir      = 1'($urandom_range(0, 1));
      d        = 1'($urandom_range(0, 1));
      load_val = 16'($urandom);
      start    = ($urandom_range(0, 4) == 0);
      count    = 5'($urandom_range(0, 20));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
